led_blink_sequencer: RTL and testbench

//   Command-driven controller for the board LED. It queues blink commands,

---
 rtl/led_blink_sequencer_if.sv | 36 +++
 rtl/led_blink_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_led_blink_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_sequencer_if
//  Description : Command channel between the host/CSR logic and the LED
//                blink sequencer (valid/ready handshake plus command fields).
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_blink_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_on_time;
    logic [CNT_W-1:0] cmd_off_time;
    logic [REP_W-1:0] cmd_repeat;

    // Command producer side (host / CSR block)
    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_on_time,
        output cmd_off_time,
        output cmd_repeat
    );

    // Command consumer side (the sequencer)
    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_on_time,
        input  cmd_off_time,
        input  cmd_repeat
    );
endinterface
`default_nettype wire

// File: rtl/led_blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_sequencer
//  Description : Queues blink commands (on-time, off-time, repeat count) in a
//                small FIFO and plays them back-to-back on the board LED
//                through ON/OFF phases. Abort flushes everything.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_sequencer #(
    parameter int CNT_W      = 16,
    parameter int REP_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    led_blink_sequencer_if.slave             cmd_if,
    input  wire logic                        abort_i,
    output logic                             led_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] mem_on_q  [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_off_q [FIFO_DEPTH];
    logic [REP_W-1:0] mem_rep_q [FIFO_DEPTH];

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    logic [CNT_W-1:0] w_head_on;
    logic [CNT_W-1:0] w_head_off;
    logic [REP_W-1:0] w_head_rep;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] timer_q,  timer_d;
    logic [REP_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] on_q,     on_d;
    logic [CNT_W-1:0] off_q,    off_d;
    logic [REP_W-1:0] rep_q,    rep_d;
    logic             led_q,    led_d;
    logic             done_q,   done_d;

    logic             w_last_period;

    assign w_full   = (count_q == CW'(FIFO_DEPTH));
    assign w_empty  = (count_q == '0);

    // Abort blocks acceptance in its own cycle so the offered command is dropped
    assign cmd_if.cmd_ready = !w_full && !abort_i;
    assign w_push   = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign w_pop    = (state_q == S_IDLE) && !w_empty && !abort_i;

    assign w_head_on  = mem_on_q[rd_ptr_q];
    assign w_head_off = mem_off_q[rd_ptr_q];
    // A repeat of 0 runs a single period
    assign w_head_rep = (mem_rep_q[rd_ptr_q] == '0) ? REP_W'(1) : mem_rep_q[rd_ptr_q];

    // rep_q is always >= 1 and period_q < rep_q, so the increment cannot wrap
    assign w_last_period = ((period_q + REP_W'(1)) >= rep_q);

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_on_q[wr_ptr_q]  <= cmd_if.cmd_on_time;
            mem_off_q[wr_ptr_q] <= cmd_if.cmd_off_time;
            mem_rep_q[wr_ptr_q] <= cmd_if.cmd_repeat;
        end
    end

    // FIFO pointers and occupancy, flushed by abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer registers, including registered LED and done outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            period_q <= '0;
            on_q     <= '0;
            off_q    <= '0;
            rep_q    <= '0;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            on_q     <= on_d;
            off_q    <= off_d;
            rep_q    <= rep_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: phase timing, period counting and command pop
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        period_d = period_q;
        on_d     = on_q;
        off_d    = off_q;
        rep_d    = rep_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    on_d     = w_head_on;
                    off_d    = w_head_off;
                    rep_d    = w_head_rep;
                    timer_d  = '0;
                    period_d = '0;
                    if (w_head_on != '0) begin
                        state_d = S_ON;
                    end else if (w_head_off != '0) begin
                        state_d = S_OFF;
                    end else begin
                        // Empty command: consumed with no LED activity
                        done_d = 1'b1;
                    end
                end
            end

            S_ON: begin
                // on_q is non-zero here, so on_q-1 never wraps
                if (timer_q == (on_q - CNT_W'(1))) begin
                    timer_d = '0;
                    if (off_q != '0) begin
                        state_d = S_OFF;
                    end else if (w_last_period) begin
                        state_d  = S_IDLE;
                        period_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        period_d = period_q + REP_W'(1);
                        state_d  = S_ON;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            S_OFF: begin
                if (timer_q == (off_q - CNT_W'(1))) begin
                    timer_d = '0;
                    if (w_last_period) begin
                        state_d  = S_IDLE;
                        period_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        period_d = period_q + REP_W'(1);
                        state_d  = (on_q != '0) ? S_ON : S_OFF;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything but reset and suppresses done
        if (abort_i) begin
            state_d  = S_IDLE;
            timer_d  = '0;
            period_d = '0;
            done_d   = 1'b0;
        end
    end

    // LED follows the next state so the output itself is a flop
    assign led_d        = (state_d == S_ON);

    assign led_o        = led_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign fifo_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_sequencer
//  Description : Directed self-checking bench for led_blink_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_sequencer;

    localparam int CNT_W      = 16;
    localparam int REP_W      = 8;
    localparam int FIFO_DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       abort;
    logic       led;
    logic       busy;
    logic       done;
    logic [2:0] fifo_count;

    int n_assert;
    int n_fail;

    // run-length monitor used by the queue test
    bit mon_en;
    int run_len;
    int nruns;
    int runs[8];
    int n_done;
    int max_count;

    led_blink_sequencer_if #(.CNT_W(CNT_W), .REP_W(REP_W)) cmd_if ();

    led_blink_sequencer #(
        .CNT_W      (CNT_W),
        .REP_W      (REP_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_if       (cmd_if),
        .abort_i      (abort),
        .led_o        (led),
        .busy_o       (busy),
        .done_o       (done),
        .fifo_count_o (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (led) begin
                run_len++;
            end else if (run_len != 0) begin
                if (nruns < 8) runs[nruns] = run_len;
                nruns++;
                run_len = 0;
            end
            if (done) n_done++;
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        end
    endtask

    task automatic drive_cmd(input int on_t, input int off_t, input int rep);
        cmd_if.cmd_valid    = 1'b1;
        cmd_if.cmd_on_time  = CNT_W'(on_t);
        cmd_if.cmd_off_time = CNT_W'(off_t);
        cmd_if.cmd_repeat   = REP_W'(rep);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mon_en   = 0;
        run_len  = 0;
        nruns    = 0;
        n_done   = 0;
        max_count = 0;
        reset    = 1'b1;
        abort    = 1'b0;
        cmd_if.cmd_valid    = 1'b0;
        cmd_if.cmd_on_time  = '0;
        cmd_if.cmd_off_time = '0;
        cmd_if.cmd_repeat   = '0;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        tick();
        check("rst_led",   led, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);

        // ---------------- test 1: on=3 off=2 rep=2 ----------------
        drive_cmd(3, 2, 2);                       // cycle 0
        check("t1_ready", cmd_if.cmd_ready, 1);
        tick();                                   // cycle 1
        cmd_if.cmd_valid = 1'b0;
        check("t1_count_c1", fifo_count, 1);
        check("t1_led_c1", led, 0);
        check("t1_busy_c1", busy, 0);
        for (int c = 2; c <= 13; c++) begin
            tick();
            check($sformatf("t1_led_c%0d", c),  led,  ((c >= 2 && c <= 4) || (c >= 7 && c <= 9)) ? 1 : 0);
            check($sformatf("t1_busy_c%0d", c), busy, (c >= 2 && c <= 11) ? 1 : 0);
            check($sformatf("t1_done_c%0d", c), done, (c == 12) ? 1 : 0);
        end

        // ---------------- test 2: A then B back-to-back ----------------
        drive_cmd(1, 1, 0);                       // cycle 0: A
        tick();                                   // cycle 1: B
        drive_cmd(2, 0, 1);
        check("t2_readyB", cmd_if.cmd_ready, 1);
        tick();                                   // cycle 2
        cmd_if.cmd_valid = 1'b0;
        check("t2_count_c2", fifo_count, 1);
        for (int c = 2; c <= 8; c++) begin
            if (c > 2) tick();
            check($sformatf("t2_led_c%0d", c),  led,  (c == 2 || c == 5 || c == 6) ? 1 : 0);
            check($sformatf("t2_busy_c%0d", c), busy, (c == 2 || c == 3 || c == 5 || c == 6) ? 1 : 0);
            check($sformatf("t2_done_c%0d", c), done, (c == 4 || c == 7) ? 1 : 0);
            if (c == 5) check("t2_count_c5", fifo_count, 0);
        end

        // ---------------- test 3: queue fills, all complete in order ----------------
        mon_en = 1;
        for (int k = 0; k < 5; k++) begin
            int guard;
            drive_cmd(20 + k, 1, 1);
            guard = 0;
            while (!cmd_if.cmd_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) check("t3_push_timeout", 1, 0);
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        check("t3_count_full", fifo_count, 4);
        check("t3_ready_full", cmd_if.cmd_ready, 0);
        // a producer holding a command while full must not disturb the queue
        drive_cmd(99, 1, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_count_hold", fifo_count, 4);
            check("t3_ready_hold", cmd_if.cmd_ready, 0);
        end
        cmd_if.cmd_valid = 1'b0;
        begin
            int guard;
            guard = 0;
            while (n_done < 5 && guard < 400) begin
                tick();
                guard++;
            end
            if (guard >= 400) check("t3_done_timeout", n_done, 5);
        end
        tick();
        mon_en = 0;
        check("t3_ndone", n_done, 5);
        check("t3_nruns", nruns, 5);
        check("t3_maxcount", max_count, 4);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_run%0d", k), runs[k], 20 + k);
        end

        // ---------------- test 4: on=0 off=0 ----------------
        drive_cmd(0, 0, 5);                       // cycle 0
        tick();                                   // cycle 1
        cmd_if.cmd_valid = 1'b0;
        check("t4_count_c1", fifo_count, 1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            check($sformatf("t4_led_c%0d", c),  led, 0);
            check($sformatf("t4_busy_c%0d", c), busy, 0);
            check($sformatf("t4_done_c%0d", c), done, (c == 2) ? 1 : 0);
        end
        check("t4_count_end", fifo_count, 0);

        // ---------------- test 5: abort in ON with two queued ----------------
        drive_cmd(10, 2, 1);                      // cycle 0: X
        tick();
        drive_cmd(10, 2, 1);                      // cycle 1: Y
        tick();
        drive_cmd(10, 2, 1);                      // cycle 2: Z
        tick();                                   // cycle 3
        check("t5_count_pre", fifo_count, 2);
        check("t5_led_pre", led, 1);
        drive_cmd(7, 7, 1);                       // offered during abort
        abort = 1'b1;
        #1;
        check("t5_ready_abort", cmd_if.cmd_ready, 0);
        tick();                                   // cycle 4
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            if (c > 4) tick();
            check($sformatf("t5_led_c%0d", c),   led, 0);
            check($sformatf("t5_busy_c%0d", c),  busy, 0);
            check($sformatf("t5_done_c%0d", c),  done, 0);
            check($sformatf("t5_count_c%0d", c), fifo_count, 0);
        end

        // ---------------- test 6: reset mid-OFF ----------------
        drive_cmd(2, 10, 1);                      // cycle 0: P
        tick();
        drive_cmd(2, 10, 1);                      // cycle 1: Q
        tick();
        drive_cmd(2, 10, 1);                      // cycle 2: R
        tick();                                   // cycle 3
        cmd_if.cmd_valid = 1'b0;
        repeat (3) tick();                        // cycle 6, in OFF
        check("t6_busy_pre", busy, 1);
        check("t6_led_pre", led, 0);
        check("t6_count_pre", fifo_count, 2);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_busy",  busy, 0);
        check("t6_rst_led",   led, 0);
        check("t6_rst_done",  done, 0);
        check("t6_rst_count", fifo_count, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        tick();
        check("t6_post_ready", cmd_if.cmd_ready, 1);
        check("t6_post_done", done, 0);
        drive_cmd(1, 1, 1);                       // cycle 0
        tick();                                   // cycle 1
        cmd_if.cmd_valid = 1'b0;
        check("t6_new_count", fifo_count, 1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("t6_led_c%0d", c),  led,  (c == 2) ? 1 : 0);
            check($sformatf("t6_busy_c%0d", c), busy, (c <= 3) ? 1 : 0);
            check($sformatf("t6_done_c%0d", c), done, (c == 4) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
